// File: rtl/vga_pkg.sv
// Shared constants for the gradient datapath: default geometry, colour widths,
// orientation codes and sequencer state encodings.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int CW_DEF       = 4;
  localparam int COORD_W      = 10;
  localparam int CHAN_W       = CW_DEF;
  localparam int COLOR_W      = 3 * CW_DEF;

  localparam logic ORIENT_H = 1'b0;
  localparam logic ORIENT_V = 1'b1;

  typedef enum logic {
    FRAME_WAIT = 1'b0,
    RUN        = 1'b1
  } seq_state_e;

endpackage

// File: rtl/grad_chan_stepper.sv
// One colour channel of the gradient: quotient/remainder walk of
// floor((A*pos + B*(N-pos))/N) using only add/subtract of d = A - B.
module grad_chan_stepper #(
  parameter int CW = 4,
  parameter int NW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NW-1:0] n_i,
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          load_i,
  input  logic          step_b_i,
  input  logic          step_i,
  output logic [CW-1:0] q_o
);

  localparam int SW = NW + 2;

  logic [CW-1:0]        quo_q, quo_d, base_q;
  logic [NW-1:0]        rem_q, rem_d, base_r;
  logic signed [CW:0]   diff;
  logic signed [SW-1:0] diff_x, n_s, r_sum;

  always_comb begin
    diff   = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
    diff_x = {{(SW-CW-1){diff[CW]}}, diff};
    // step_b restarts the walk from (B, 0) instead of the held state
    base_q = step_b_i ? b_i : quo_q;
    base_r = step_b_i ? '0 : rem_q;
    n_s    = $signed({2'b00, n_i});
    r_sum  = $signed({2'b00, base_r}) + diff_x;
    quo_d  = base_q;
    rem_d  = r_sum[NW-1:0];
    if (r_sum >= n_s) begin
      quo_d = base_q + 1'b1;
      rem_d = NW'(r_sum - n_s);
    end else if (r_sum[SW-1]) begin
      quo_d = base_q - 1'b1;
      rem_d = NW'(r_sum + n_s);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
    end else if (load_i) begin
      quo_q <= b_i;
      rem_q <= '0;
    end else if (step_b_i || step_i) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign q_o = quo_q;

endmodule

// File: rtl/gradient_seq_ctrl.sv
// Gradient controller: shadow command registers, tear-free commit at frame start,
// and three channel steppers. GRAD_SWAP_EN adds the cmd_swap (exchange A/B) command.
module gradient_seq_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3*CW-1:0]     sw,
  input  logic                cmd_load_a,
  input  logic                cmd_load_b,
  input  logic                cmd_toggle,
`ifdef GRAD_SWAP_EN
  input  logic                cmd_swap,
`endif
  input  logic                p_tick,
  input  logic                video_on,
  input  logic [COORD_W-1:0]  x,
  input  logic [COORD_W-1:0]  y,
  output logic [3*CW-1:0]     rgb,
  output logic                pending
);

  localparam int COLW = 3 * CW;

  seq_state_e        state_q;
  logic [COLW-1:0]   sh_a_q, sh_b_q, act_a_q, act_b_q, rgb_q;
  logic [COLW-1:0]   sh_a_d, sh_b_d, eff_a, eff_b, q_all, rgb_d;
  logic              sh_orient_q, sh_orient_d, act_orient_q, eff_orient;
  logic              pending_q;
  logic              frame_start, cmd_any, pix_en, horiz, x_zero, x_last;
  logic              ld_v, step_b, step_n, use_b;
  logic [COORD_W-1:0] n_sel;

  assign frame_start = p_tick && (x == '0) && (y == '0);

`ifdef GRAD_SWAP_EN
  assign cmd_any = cmd_load_a | cmd_load_b | cmd_toggle | cmd_swap;
`else
  assign cmd_any = cmd_load_a | cmd_load_b | cmd_toggle;
`endif

  always_comb begin
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    sh_orient_d = sh_orient_q ^ cmd_toggle;
`ifdef GRAD_SWAP_EN
    if (cmd_swap) begin
      sh_a_d = sh_b_q;
      sh_b_d = sh_a_q;
    end
`endif
    if (cmd_load_a) sh_a_d = sw;
    if (cmd_load_b) sh_b_d = sw;
  end

  // The frame-start pixel already uses the settings being committed on that edge
  assign eff_a      = frame_start ? sh_a_q      : act_a_q;
  assign eff_b      = frame_start ? sh_b_q      : act_b_q;
  assign eff_orient = frame_start ? sh_orient_q : act_orient_q;

  assign pix_en = p_tick && video_on && ((state_q == RUN) || frame_start);
  assign horiz  = (eff_orient == ORIENT_H);
  assign x_zero = (x == '0);
  assign x_last = (x == COORD_W'(H_ACTIVE - 1));
  assign n_sel  = horiz ? COORD_W'(H_ACTIVE) : COORD_W'(V_ACTIVE);

  assign ld_v   = pix_en && !horiz && frame_start;
  assign step_b = pix_en && horiz && x_zero;
  assign step_n = pix_en && (horiz ? !x_zero : x_last);
  assign use_b  = horiz ? x_zero : frame_start;

  for (genvar c = 0; c < 3; c++) begin : g_chan
    grad_chan_stepper #(.CW(CW), .NW(COORD_W)) u_step (
      .clk      (clk),
      .reset    (reset),
      .n_i      (n_sel),
      .a_i      (eff_a[c*CW +: CW]),
      .b_i      (eff_b[c*CW +: CW]),
      .load_i   (ld_v),
      .step_b_i (step_b),
      .step_i   (step_n),
      .q_o      (q_all[c*CW +: CW])
    );
  end

  always_comb begin
    rgb_d = '0;
    if (pix_en) rgb_d = use_b ? eff_b : q_all;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FRAME_WAIT;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      sh_orient_q  <= ORIENT_H;
      act_a_q      <= '0;
      act_b_q      <= '0;
      act_orient_q <= ORIENT_H;
      pending_q    <= 1'b0;
      rgb_q        <= '0;
    end else begin
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      sh_orient_q <= sh_orient_d;
      if (frame_start) begin
        act_a_q      <= sh_a_q;
        act_b_q      <= sh_b_q;
        act_orient_q <= sh_orient_q;
      end
      // a command in the commit cycle keeps pending for the next frame
      if (cmd_any)          pending_q <= 1'b1;
      else if (frame_start) pending_q <= 1'b0;
      case (state_q)
        FRAME_WAIT: if (frame_start) state_q <= RUN;
        RUN:        state_q <= RUN;
        default:    state_q <= FRAME_WAIT;
      endcase
      if (p_tick) rgb_q <= rgb_d;
    end
  end

  assign rgb     = rgb_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_gradient_seq_ctrl.sv
// Directed bench for gradient_seq_ctrl: table of ramp sample points plus
// hand sequences for commit timing, blanking, reset and the optional swap.
module tb_gradient_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sw = '0;
  logic        cmd_load_a = 1'b0, cmd_load_b = 1'b0, cmd_toggle = 1'b0;
`ifdef GRAD_SWAP_EN
  logic        cmd_swap = 1'b0;
`endif
  logic        p_tick = 1'b0, video_on = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [11:0] rgb;
  logic        pending;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        vert;
    int          pos;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[6];

  gradient_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .cmd_load_a (cmd_load_a),
    .cmd_load_b (cmd_load_b),
    .cmd_toggle (cmd_toggle),
`ifdef GRAD_SWAP_EN
    .cmd_swap   (cmd_swap),
`endif
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .rgb        (rgb),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_px(input logic [11:0] a, input logic [11:0] b,
                                         input int pos, input int n);
    logic [11:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      int av, bv;
      av = int'(a[c*4 +: 4]);
      bv = int'(b[c*4 +: 4]);
      r[c*4 +: 4] = 4'((av * pos + bv * (n - pos)) / n);
    end
    return r;
  endfunction

  task automatic clear_cmds();
    cmd_load_a = 1'b0;
    cmd_load_b = 1'b0;
    cmd_toggle = 1'b0;
`ifdef GRAD_SWAP_EN
    cmd_swap = 1'b0;
`endif
  endtask

  task automatic pix(input int xx, input int yy, input logic von);
    x = 10'(xx);
    y = 10'(yy);
    video_on = von;
    p_tick = 1'b1;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    clear_cmds();
  endtask

  task automatic cmd(input logic la, input logic lb, input logic tg, input logic [11:0] v);
    sw = v;
    cmd_load_a = la;
    cmd_load_b = lb;
    cmd_toggle = tg;
    @(posedge clk);
    #1;
    clear_cmds();
  endtask

  task automatic hline(input int yy, input logic [11:0] a, input logic [11:0] b,
                       input logic use_tbl, input string name);
    int errs;
    errs = 0;
    for (int xx = 0; xx < 640; xx++) begin
      pix(xx, yy, 1'b1);
      if (rgb !== ref_px(a, b, xx, 640)) errs++;
      if (use_tbl)
        for (int i = 0; i < 6; i++)
          if (!tbl[i].vert && tbl[i].pos == xx)
            check($sformatf("h_tbl_x%0d", xx), rgb, tbl[i].exp);
    end
    check(name, errs, 0);
  endtask

  task automatic vrows(input int y0, input int y1, input logic [11:0] a, input logic [11:0] b,
                       input logic use_tbl, input string name);
    int errs;
    int xs[3];
    errs = 0;
    xs = '{0, 100, 639};
    for (int yy = y0; yy <= y1; yy++) begin
      for (int k = 0; k < 3; k++) begin
        pix(xs[k], yy, 1'b1);
        if (rgb !== ref_px(a, b, yy, 480)) errs++;
        if (use_tbl && xs[k] == 100)
          for (int i = 0; i < 6; i++)
            if (tbl[i].vert && tbl[i].pos == yy)
              check($sformatf("v_tbl_y%0d", yy), rgb, tbl[i].exp);
      end
    end
    check(name, errs, 0);
  endtask

  initial begin
    tbl[0] = '{vert: 1'b0, pos: 0,   exp: 12'h00F};
    tbl[1] = '{vert: 1'b0, pos: 320, exp: 12'h707};
    tbl[2] = '{vert: 1'b0, pos: 639, exp: 12'hE00};
    tbl[3] = '{vert: 1'b1, pos: 0,   exp: 12'h00F};
    tbl[4] = '{vert: 1'b1, pos: 240, exp: 12'h707};
    tbl[5] = '{vert: 1'b1, pos: 479, exp: 12'hE00};

    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", rgb, 12'h000);
    check("rst_pending", pending, 1'b0);
    reset = 1'b0;

    // horizontal ramp
    cmd(1'b1, 1'b0, 1'b0, 12'hF00);
    check("pend_after_load_a", pending, 1'b1);
    cmd(1'b0, 1'b1, 1'b0, 12'h00F);
    pix(0, 0, 1'b1);
    check("fs_pending_clear", pending, 1'b0);
    check("fs_first_pixel", rgb, 12'h00F);
    hline(0, 12'hF00, 12'h00F, 1'b1, "h_line0");
    pix(640, 0, 1'b0);
    check("blank_rgb", rgb, 12'h000);
    hline(1, 12'hF00, 12'h00F, 1'b0, "h_line1");

    // vertical ramp
    cmd(1'b0, 1'b0, 1'b1, 12'h000);
    check("pend_after_toggle", pending, 1'b1);
    vrows(0, 479, 12'hF00, 12'h00F, 1'b1, "v_frame");
    check("v_pending_clear", pending, 1'b0);

    // tear-free commit mid-frame
    vrows(0, 199, 12'hF00, 12'h00F, 1'b0, "tear_pre");
    cmd(1'b0, 1'b1, 1'b0, 12'h0F0);
    check("tear_pending_set", pending, 1'b1);
    vrows(200, 479, 12'hF00, 12'h00F, 1'b0, "tear_rest_old");
    check("tear_pending_hold", pending, 1'b1);
    vrows(0, 479, 12'hF00, 12'h0F0, 1'b0, "tear_new_frame");
    check("tear_pending_clear", pending, 1'b0);

    // command landing in the frame-start cycle
    sw = 12'h0A5;
    cmd_load_a = 1'b1;
    vrows(0, 479, 12'hF00, 12'h0F0, 1'b0, "fs_cmd_not_applied");
    check("fs_cmd_pending", pending, 1'b1);
    vrows(0, 479, 12'h0A5, 12'h0F0, 1'b0, "fs_cmd_applied");
    check("fs_cmd_pending_clear", pending, 1'b0);

    // simultaneous loads capture the same value
    cmd(1'b1, 1'b1, 1'b0, 12'h321);
    vrows(0, 2, 12'h321, 12'h321, 1'b0, "dual_load");

    // double toggle cancels orientation, pending remains
    cmd(1'b1, 1'b0, 1'b0, 12'hF00);
    cmd(1'b0, 1'b1, 1'b0, 12'h00F);
    cmd(1'b0, 1'b0, 1'b1, 12'h000);
    cmd(1'b0, 1'b0, 1'b1, 12'h000);
    check("dbl_toggle_pending", pending, 1'b1);
    vrows(0, 299, 12'hF00, 12'h00F, 1'b0, "dbl_toggle_vertical");

    // reset mid-frame
    cmd(1'b1, 1'b0, 1'b0, 12'h0F0);
    #2 reset = 1'b1;
    #1;
    check("midrst_rgb", rgb, 12'h000);
    check("midrst_pending", pending, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pix(0, 300, 1'b1);
    check("wait_rgb_a", rgb, 12'h000);
    cmd(1'b1, 1'b0, 1'b0, 12'hF00);
    cmd(1'b0, 1'b1, 1'b0, 12'h00F);
    pix(100, 301, 1'b1);
    check("wait_rgb_b", rgb, 12'h000);
    pix(639, 301, 1'b1);
    check("wait_rgb_c", rgb, 12'h000);
    hline(0, 12'hF00, 12'h00F, 1'b0, "resume_h_line");
    check("resume_pending", pending, 1'b0);

`ifdef GRAD_SWAP_EN
    cmd_swap = 1'b1;
    @(posedge clk);
    #1;
    clear_cmds();
    check("swap_pending", pending, 1'b1);
    pix(0, 0, 1'b1);
    check("swap_x0", rgb, 12'hF00);
    hline(0, 12'h00F, 12'hF00, 1'b0, "swap_line");
    check("swap_x639", rgb, 12'h00E);
    cmd(1'b1, 1'b0, 1'b0, 12'hF00);
    cmd(1'b0, 1'b1, 1'b0, 12'h00F);
    sw = 12'h0F0;
    cmd_swap = 1'b1;
    cmd_load_a = 1'b1;
    @(posedge clk);
    #1;
    clear_cmds();
    pix(0, 0, 1'b1);
    check("swap_load_b", rgb, 12'hF00);
    hline(0, 12'h0F0, 12'hF00, 1'b0, "swap_load_line");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
